muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have no parameters; all datapaths are fixed at 32 bits and register addresses at 5 bits.
REQ-002 SHALL use a single clock and a synchronous, active-high reset: clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  request to launch an operation; accepted only when busy=0.
REQ-006 op  input  2  operation select: 00 MUL low word, 01 MUL high word, 10 DIV quotient, 11 DIV remainder (all unsigned).
REQ-007 a  input  32  operand A (multiplicand or dividend).
REQ-008 b  input  32  operand B (multiplier or divisor).
REQ-009 dest  input  5  destination register address for the result.
REQ-010 busy  output  1  high while an accepted operation is in flight.
REQ-011 wb_we  output  1  one-cycle write strobe; connects to the register file's second write enable (WE2).
REQ-012 wb_addr  output  5  result register address; connects to write_addr2.
REQ-013 wb_data  output  32  result value; connects to data2.
REQ-014 div_zero  output  1  high together with wb_we when a DIV op had b=0.

Function
REQ-015 The FSM SHALL have three states, IDLE, RUN and DONE, each with one function:
- IDLE: waits for a request.
- RUN: performs one shift/add (MUL) or one shift/subtract restoring step (DIV) per cycle.
- DONE: presents the result for exactly one cycle.
REQ-016 Acceptance edge (edge 0) SHALL be a rising edge with state=IDLE and start=1. At that edge:
- latch a, b, op and dest into internal registers;
- clear the 5-bit iteration counter;
- move to RUN.
REQ-017 Changes to a, b, op, dest or start after edge 0 SHALL NOT affect the operation in flight.
REQ-018 RUN SHALL perform exactly 32 iterations, at edges 1..32; edge 32 SHALL move the FSM to DONE.
REQ-019 During the DONE cycle (edge 32 to edge 33):
- wb_we=1;
- wb_addr = latched dest;
- wb_data = selected result;
- div_zero valid.
REQ-020 Edge 33 SHALL return the FSM to IDLE; wb_we and div_zero SHALL be 0 in every cycle other than DONE.
REQ-021 busy SHALL be 1 from edge 0 through edge 33 exclusive, covering RUN and DONE, and 0 in IDLE.
REQ-022 Accept-to-strobe latency SHALL be a fixed 32 cycles; a new request SHALL be accepted no earlier than edge 33, for a minimum issue interval of 33 cycles.
REQ-023 start asserted while busy=1, including during the DONE cycle, SHALL be ignored, not queued.
REQ-024 MUL SHALL form the full 64-bit unsigned product; op 00 returns bits [31:0] and op 01 returns bits [63:32].
REQ-025 DIV SHALL return the unsigned quotient (op 10) or the remainder (op 11), with remainder < b.
REQ-026 DIV with b=0 SHALL still take 32 iterations, then return:
- quotient 0xFFFFFFFF;
- remainder = a;
- div_zero=1 in the DONE cycle.
REQ-027 A MUL op SHALL never assert div_zero, including when b=0.
REQ-028 dest=0 SHALL be written like any other address; register-0 policy belongs to the register file.
REQ-029 wb_addr and wb_data SHALL be registered; outside DONE they hold their last values and carry no meaning.

Reset
REQ-030 rst=1 at any edge SHALL force state IDLE, clear the counter, and drive busy=0, wb_we=0, wb_addr=0, wb_data=0, div_zero=0.
REQ-031 rst SHALL take priority over start at the same edge; no operation is accepted on that edge.
REQ-032 rst during RUN or DONE SHALL abort the operation with no write strobe issued afterwards.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- MUL low: a=7, b=6, op=00, dest=5 -> wb_we for one cycle exactly 32 cycles after accept, wb_addr=5, wb_data=42, div_zero=0.
- MUL high/low: a=b=0xFFFFFFFF -> op=01 gives 0xFFFFFFFE; op=00 gives 0x00000001.
- DIV: a=100, b=7 -> op=10 gives 14, op=11 gives 2.
- Divide by zero: a=0x1234, b=0 -> op=10 gives 0xFFFFFFFF with div_zero=1; op=11 gives 0x1234 with div_zero=1.
- Busy ignore: second start with a=3, b=3 at cycle 5 after accept -> only the first result is written; busy drops at edge 33; re-asserting start then is accepted.
- Reset mid-op: rst at edge 10 after accept -> busy=0 next cycle, no wb_we for 40 cycles, all outputs 0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32-bit unsigned multiply/divide unit: one shift/add or restoring-divide step per
// cycle, then a single-cycle write-back strobe toward the register file's second write port.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  dest,
    output logic        busy,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  dest_q, dest_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;

    logic [32:0] mul_sum;
    logic [32:0] rem_shift;
    logic        div_ge;
    logic [31:0] rem_sub;
    logic [63:0] step;

    // acc holds {partial product high, multiplier} for MUL and {remainder, dividend/quotient}
    // for DIV, so both final results land as {high/remainder, low/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
        rem_shift = {acc_q[63:32], acc_q[31]};
        div_ge    = (rem_shift >= {1'b0, b_q});
        rem_sub   = rem_shift[31:0] - b_q;
        if (op_q[1]) begin
            if (div_ge) begin
                step = {rem_sub, acc_q[30:0], 1'b1};
            end else begin
                step = {rem_shift[31:0], acc_q[30:0], 1'b0};
            end
        end else begin
            step = {mul_sum, acc_q[31:1]};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        b_d       = b_q;
        dest_d    = dest_q;
        acc_d     = acc_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d    = op;
                    b_d     = b;
                    dest_d  = dest;
                    acc_d   = {32'd0, a};
                    cnt_d   = 5'd0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d   = StDone;
                    wb_addr_d = dest_q;
                    wb_data_d = op_q[0] ? step[63:32] : step[31:0];
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 5'd0;
            op_q      <= 2'd0;
            b_q       <= 32'd0;
            dest_q    <= 5'd0;
            acc_q     <= 64'd0;
            wb_addr_q <= 5'd0;
            wb_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            b_q       <= b_d;
            dest_q    <= dest_d;
            acc_q     <= acc_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign wb_we    = (state_q == StDone);
    assign div_zero = wb_we && op_q[1] && (b_q == 32'd0);
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model checked every cycle, plus
// hand-computed literal results and latencies for the key scenarios.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic        busy;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        div_zero;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .dest     (dest),
        .busy     (busy),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        logic [63:0] p;
        p = {32'd0, x} * {32'd0, y};
        case (o)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            default: return (y == 32'd0) ? x : x % y;
        endcase
    endfunction

    // Reference model: an accepted op is busy for 33 cycles, its result shows in the 33rd.
    logic        m_valid = 1'b0;
    logic        m_busy  = 1'b0;
    logic        m_clean = 1'b1;
    logic        m_dz    = 1'b0;
    int          m_age   = 0;
    logic [31:0] m_data  = 32'd0;
    logic [4:0]  m_dest  = 5'd0;
    logic        exp_we;

    assign exp_we = m_busy && (m_age == 32);

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b1;
            m_busy  <= 1'b0;
            m_clean <= 1'b1;
            m_age   <= 0;
        end else if (m_busy) begin
            m_age <= m_age + 1;
            if (m_age == 31) m_clean <= 1'b0;
            if (m_age == 32) m_busy <= 1'b0;
        end else if (start) begin
            m_busy <= 1'b1;
            m_age  <= 0;
            m_data <= ref_result(op, a, b);
            m_dest <= dest;
            m_dz   <= op[1] && (b == 32'd0);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model busy", busy, m_busy);
            check("model wb_we", wb_we, exp_we);
            check("model div_zero", div_zero, exp_we && m_dz);
            if (exp_we) begin
                check("model wb_addr", wb_addr, m_dest);
                check("model wb_data", wb_data, m_data);
            end else if (m_clean) begin
                check("model wb_addr cleared", wb_addr, 32'd0);
                check("model wb_data cleared", wb_data, 32'd0);
            end
        end
    end

    // Called at a negedge with the unit idle; afterwards the bench sits at the negedge
    // following the accept edge, with the inputs scrambled.
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] d);
        op    = o;
        a     = x;
        b     = y;
        dest  = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        dest  = 5'($urandom);
    endtask

    task automatic wait_result(input string name, input int lat0, input logic [31:0] exp_d,
                               input logic [4:0] exp_a, input logic exp_dz);
        int lat;
        lat = lat0;
        while (!wb_we && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, lat, 32);
        check({name, " data"}, wb_data, exp_d);
        check({name, " addr"}, wb_addr, exp_a);
        check({name, " div_zero"}, div_zero, exp_dz);
    endtask

    task automatic finish_op(input string name);
        @(negedge clk);
        check({name, " strobe ends"}, wb_we, 1'b0);
        check({name, " busy ends"}, busy, 1'b0);
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] d, input logic [31:0] exp_d,
                          input logic exp_dz);
        launch(o, x, y, d);
        wait_result(name, 0, exp_d, d, exp_dz);
        finish_op(name);
    endtask

    initial begin
        int strobes;
        rst   = 1'b1;
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd5;
        b     = 32'd5;
        dest  = 5'd3;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset wb_we", wb_we, 1'b0);
        check("reset wb_addr", wb_addr, 32'd0);
        check("reset wb_data", wb_data, 32'd0);
        check("reset div_zero", div_zero, 1'b0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

        run_op("mul_lo 7*6", 2'b00, 32'd7, 32'd6, 5'd5, 32'd42, 1'b0);
        run_op("mul_hi max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 1'b0);
        run_op("mul_lo max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0001, 1'b0);
        run_op("div_q 100/7", 2'b10, 32'd100, 32'd7, 5'd3, 32'd14, 1'b0);
        run_op("div_r 100/7", 2'b11, 32'd100, 32'd7, 5'd4, 32'd2, 1'b0);
        run_op("div_q by 0", 2'b10, 32'h1234, 32'd0, 5'd6, 32'hFFFF_FFFF, 1'b1);
        run_op("div_r by 0", 2'b11, 32'h1234, 32'd0, 5'd7, 32'h1234, 1'b1);
        run_op("mul by 0", 2'b01, 32'd9, 32'd0, 5'd8, 32'd0, 1'b0);
        run_op("mul_hi dest0", 2'b01, 32'h0001_0000, 32'h0001_0000, 5'd0, 32'd1, 1'b0);
        run_op("div_q big", 2'b10, 32'hFFFF_FFFF, 32'h10, 5'd31, 32'h0FFF_FFFF, 1'b0);
        run_op("div_r big", 2'b11, 32'hFFFF_FFFF, 32'h10, 5'd30, 32'hF, 1'b0);
        run_op("div_r top", 2'b11, 32'h8000_0001, 32'h8000_0000, 5'd10, 32'd1, 1'b0);

        // Busy ignore: a start at edge 5 is dropped; one held through DONE lands at edge 34.
        launch(2'b00, 32'd10, 32'd3, 5'd9);
        repeat (4) @(negedge clk);
        op    = 2'b00;
        a     = 32'd3;
        b     = 32'd3;
        dest  = 5'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_result("ignore first", 5, 32'd30, 5'd9, 1'b0);
        start = 1'b1;
        @(negedge clk);
        check("ignore busy drop", busy, 1'b0);
        check("ignore no 2nd strobe", wb_we, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("ignore reaccept busy", busy, 1'b1);
        wait_result("ignore second", 0, 32'd9, 5'd7, 1'b0);
        finish_op("ignore second");

        // Reset mid-op at edge 10 after accept.
        launch(2'b10, 32'd1000, 32'd3, 5'd12);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", busy, 1'b0);
        check("abort wb_we", wb_we, 1'b0);
        check("abort wb_addr", wb_addr, 32'd0);
        check("abort wb_data", wb_data, 32'd0);
        check("abort div_zero", div_zero, 1'b0);
        strobes = 0;
        repeat (40) begin
            @(negedge clk);
            if (wb_we) strobes++;
        end
        check("abort no strobe", strobes, 32'd0);

        run_op("after abort", 2'b00, 32'd123, 32'd1000, 5'd11, 32'd123000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
